adc_spi_sampler: RTL and testbench

- SPI master for the 10-bit serial ADC on each hydrophone channel.
- Runs conversions at a fixed sample rate and deserializes each ADC frame.
- Presents every sample as a parallel word plus a multi-cycle ready strobe. This is the sample-producing side of the ring-buffer input: `data_out` drives `Input_Data` and `data_ready` drives `Input_Data_Ready`.
- `data_ready` also feeds the FFT trigger logic.

---
 rtl/adc_spi_sampler_if.sv | 33 +++
 rtl/adc_spi_sampler.sv | 157 +++++++++++++++
 tb/tb_adc_spi_sampler.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_sampler_if.sv
// Hydrophone ADC sampler bus: SPI pins to the ADC plus the parallel
// sample port feeding the ring buffer and FFT trigger.
interface adc_spi_sampler_if #(
   parameter int DATA_WIDTH = 10
);
   logic                  enable;
   logic                  adc_sdata;
   logic                  adc_cs_n;
   logic                  adc_sclk;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_ready;
   logic                  lead_err;

   modport master (
      input  enable,
      input  adc_sdata,
      output adc_cs_n,
      output adc_sclk,
      output data_out,
      output data_ready,
      output lead_err
   );

   modport slave (
      output enable,
      output adc_sdata,
      input  adc_cs_n,
      input  adc_sclk,
      input  data_out,
      input  data_ready,
      input  lead_err
   );
endinterface

// File: rtl/adc_spi_sampler.sv
// SPI master for the 10-bit hydrophone ADC; fixed-rate conversions.
// Define ADC_TWOS_COMP_EN to present samples as two's complement.
module adc_spi_sampler #(
   parameter int CLK_DIV       = 5,
   parameter int SAMPLE_PERIOD = 196,
   parameter int READY_CYCLES  = 14,
   parameter int DATA_WIDTH    = 10,
   parameter int LEAD_BITS     = 4
) (
   input logic               clk,
   input logic               reset,
   adc_spi_sampler_if.master bus
);
   localparam int FRAME = 16;
   localparam int TW    = $clog2(CLK_DIV);
   localparam int PW    = $clog2(SAMPLE_PERIOD);
   localparam int RW    = $clog2(READY_CYCLES + 1);
   localparam int TAIL  = FRAME - LEAD_BITS - DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE, SETUP, SHIFT, HOLD, PRESENT
   } state_t;

   state_t                state, nstate;
   logic [TW-1:0]         tick, ntick;
   logic [3:0]            bitn, nbit;
   logic                  nhi, tick_end;
   logic                  cs_n, sclk, ncs_n, nsclk;
   logic                  capture, load;
   logic [PW-1:0]         pcnt;
   logic [FRAME-1:0]      shreg;
   logic [RW-1:0]         rcnt;
   logic [DATA_WIDTH-1:0] raw, sample, data_q;
   logic                  ready_q, lead_q, lead_any;

   assign tick_end = (tick == TW'(CLK_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         tick  <= '0;
         bitn  <= '0;
         cs_n  <= 1'b1;
         sclk  <= 1'b1;
         shreg <= '0;
      end else begin
         state <= nstate;
         tick  <= ntick;
         bitn  <= nbit;
         cs_n  <= ncs_n;
         sclk  <= nsclk;
         if (capture)
            shreg <= {shreg[FRAME-2:0], bus.adc_sdata};
      end
   end

   // The final SCLK high half doubles as HOLD, so CS rises right after it.
   always_comb begin
      nstate = state;
      ntick  = tick + TW'(1);
      nbit   = bitn;
      nhi    = 1'b1;
      unique case (state)
         IDLE: begin
            ntick = '0;
            if (bus.enable && pcnt == '0)
               nstate = SETUP;
         end
         SETUP: begin
            if (tick_end) begin
               nstate = SHIFT;
               ntick  = '0;
               nbit   = '0;
               nhi    = 1'b0;
            end
         end
         SHIFT: begin
            nhi = sclk;
            if (tick_end) begin
               ntick = '0;
               nhi   = !sclk;
               if (!sclk && bitn == 4'd15)
                  nstate = HOLD;
               if (sclk)
                  nbit = bitn + 4'd1;
            end
         end
         HOLD: begin
            if (tick_end) begin
               nstate = PRESENT;
               ntick  = '0;
            end
         end
         PRESENT: begin
            nstate = IDLE;
            ntick  = '0;
         end
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      ncs_n   = !(nstate inside {SETUP, SHIFT, HOLD});
      nsclk   = (nstate != SHIFT) || nhi;
      capture = (state == SHIFT) && !sclk && tick_end;
      load    = (state == PRESENT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pcnt <= '0;
      else if (!bus.enable)
         pcnt <= '0;
      else if (pcnt == PW'(SAMPLE_PERIOD - 1))
         pcnt <= '0;
      else
         pcnt <= pcnt + PW'(1);
   end

   assign lead_any = |(shreg >> (FRAME - LEAD_BITS));
   assign raw      = DATA_WIDTH'(shreg >> TAIL);

`ifdef ADC_TWOS_COMP_EN
   assign sample = raw ^ {1'b1, {(DATA_WIDTH-1){1'b0}}};
`else
   assign sample = raw;
`endif

   // A load arriving while ready is high is dropped to keep data_out stable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         ready_q <= 1'b0;
         lead_q  <= 1'b0;
         rcnt    <= '0;
      end else begin
         lead_q <= 1'b0;
         if (load && !ready_q) begin
            data_q  <= sample;
            ready_q <= 1'b1;
            lead_q  <= lead_any;
            rcnt    <= RW'(READY_CYCLES - 1);
         end else if (ready_q) begin
            if (rcnt == '0)
               ready_q <= 1'b0;
            else
               rcnt <= rcnt - RW'(1);
         end
      end
   end

   assign bus.adc_cs_n   = cs_n;
   assign bus.adc_sclk   = sclk;
   assign bus.data_out   = data_q;
   assign bus.data_ready = ready_q;
   assign bus.lead_err   = lead_q;
endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: ADC frame model, frame-level reference
// model and a scoreboard monitor checking every presented sample.
module tb_adc_spi_sampler;
   localparam int LEAD   = 4;
   localparam int DW     = 10;
   localparam int PERIOD = 196;

   typedef struct {
      int data;
      int lead;
   } exp_t;

   logic clk     = 1'b0;
   logic reset   = 1'b0;
   logic sdata_m = 1'b0;

   int cyc        = 0;
   int checks     = 0;
   int errors     = 0;
   int falls      = 0;
   int readies    = 0;
   int last_fall  = 0;
   int last_rises = 0;
   int rises      = 0;
   int bitp       = 0;
   int cur        = 0;
   int rcnt       = 0;
   int held       = 0;
   bit cont_mode    = 1'b0;
   bit fall_in_cont = 1'b0;
   logic m_cs    = 1'b1;
   logic m_sclk  = 1'b1;
   logic prev_cs = 1'b1;
   logic prev_rdy = 1'b0;

   exp_t exp_q[$];
   exp_t e;
   int   frames[$];

   adc_spi_sampler_if #(.DATA_WIDTH(DW)) bus ();

   adc_spi_sampler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.adc_sdata = sdata_m;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endfunction

   function automatic int mk(int lead, int s, int t);
      return (lead << (16 - LEAD)) | (s << (16 - LEAD - DW)) | t;
   endfunction

   // Frame-level reference: pick fields out of the 16-bit frame.
   function automatic exp_t ref_model(int frame);
      exp_t r;
      r.data = (frame >> (16 - LEAD - DW)) & ((1 << DW) - 1);
      r.lead = ((frame >> (16 - LEAD)) != 0) ? 1 : 0;
`ifdef ADC_TWOS_COMP_EN
      r.data = r.data ^ (1 << (DW - 1));
`endif
      return r;
   endfunction

   // ADC: bit 0 valid at CS fall, next bit after each SCLK fall.
   always @(bus.adc_cs_n or bus.adc_sclk) begin
      if (m_cs === 1'b1 && bus.adc_cs_n === 1'b0) begin
         if (frames.size() > 0)
            cur = frames.pop_front();
         else
            cur = int'($urandom_range(0, 4095));
         bitp    = 0;
         rises   = 0;
         sdata_m = cur[15];
         exp_q.push_back(ref_model(cur));
      end else if (bus.adc_cs_n === 1'b0) begin
         if (m_sclk === 1'b1 && bus.adc_sclk === 1'b0 && rises > 0) begin
            bitp++;
            if (bitp < 16)
               sdata_m = cur[15 - bitp];
         end
         if (m_sclk === 1'b0 && bus.adc_sclk === 1'b1)
            rises++;
      end
      if (m_cs === 1'b0 && bus.adc_cs_n === 1'b1)
         last_rises = rises;
      m_cs   = bus.adc_cs_n;
      m_sclk = bus.adc_sclk;
   end

   always @(negedge clk) begin
      if (!cont_mode)
         fall_in_cont = 1'b0;
      if (reset) begin
         exp_q.delete();
         held = 0;
      end else begin
         if (prev_cs === 1'b1 && bus.adc_cs_n === 1'b0) begin
            falls++;
            if (cont_mode && fall_in_cont)
               chk("cs_period", cyc - last_fall, PERIOD);
            fall_in_cont = cont_mode;
            last_fall    = cyc;
         end
         if (prev_cs === 1'b0 && bus.adc_cs_n === 1'b1)
            chk("cs_rise", cyc - last_fall, 165);
         if (bus.data_ready && !prev_rdy) begin
            readies++;
            if (exp_q.size() == 0) begin
               chk("unexpected_ready", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               chk("data", int'(bus.data_out), e.data);
               chk("lead_err", int'(bus.lead_err), e.lead);
               chk("ready_latency", cyc - last_fall, 166);
               chk("sclk_rises", last_rises, 16);
            end
            held = int'(bus.data_out);
            rcnt = 1;
         end else if (bus.data_ready) begin
            rcnt++;
            chk("data_hold", int'(bus.data_out), held);
         end else if (int'(bus.data_out) != held) begin
            chk("data_idle_hold", int'(bus.data_out), held);
         end
         if (!bus.data_ready && prev_rdy)
            chk("ready_width", rcnt, 14);
         if (bus.lead_err && !(bus.data_ready && !prev_rdy))
            chk("lead_err_stray", int'(bus.lead_err), 0);
      end
      prev_cs  = bus.adc_cs_n;
      prev_rdy = bus.data_ready;
   end

   task automatic wait_falls(int n, int budget);
      int k = 0;
      while (falls < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      chk("cs_fall_timeout", (falls >= n) ? 1 : 0, 1);
   endtask

   task automatic wait_readies(int n, int budget);
      int k = 0;
      while (readies < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      chk("ready_timeout", (readies >= n) ? 1 : 0, 1);
   endtask

   task automatic start_enable();
      int en_at;
      int f0;
      @(posedge clk);
      #1;
      en_at      = cyc;
      f0         = falls;
      bus.enable = 1'b1;
      wait_falls(f0 + 1, 20);
      chk("enable_to_cs", last_fall - en_at, 1);
   endtask

   task automatic stop_and_idle(int n);
      @(posedge clk);
      #1;
      bus.enable = 1'b0;
      repeat (n) @(posedge clk);
      cont_mode = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   initial begin
      int r0;
      int f0;
      bus.enable = 1'b0;
      reset      = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs_n", int'(bus.adc_cs_n), 1);
      chk("rst_sclk", int'(bus.adc_sclk), 1);
      chk("rst_data", int'(bus.data_out), 0);
      chk("rst_ready", int'(bus.data_ready), 0);
      chk("rst_lead", int'(bus.lead_err), 0);
      reset = 1'b0;

      // single frame, 0x2A5
      r0 = readies;
      frames.push_back(mk(0, 'h2A5, int'($urandom_range(0, 3))));
      start_enable();
      wait_readies(r0 + 1, 400);
      stop_and_idle(250);

      // continuous incrementing samples
      r0 = readies;
      cont_mode = 1'b1;
      for (int i = 0; i < 8; i++)
         frames.push_back(mk(0, i, int'($urandom_range(0, 3))));
      start_enable();
      wait_readies(r0 + 8, 8 * PERIOD + 400);
      stop_and_idle(250);

      // lead bit, extremes and fully random frames
      r0 = readies;
      cont_mode = 1'b1;
      frames.push_back(mk(4, int'($urandom_range(0, 1023)),
                          int'($urandom_range(0, 3))));
      frames.push_back(mk(0, 'h3FF, 0));
      frames.push_back(mk(0, 0, 3));
      for (int i = 0; i < 5; i++)
         frames.push_back(int'($urandom_range(0, 65535)));
      start_enable();
      wait_readies(r0 + 8, 8 * PERIOD + 400);
      stop_and_idle(250);

      // enable dropped mid-frame
      r0 = readies;
      f0 = falls;
      start_enable();
      repeat (49) @(posedge clk);
      #1;
      bus.enable = 1'b0;
      wait_readies(r0 + 1, 300);
      repeat (300) @(posedge clk);
      chk("no_cs_after_disable", falls, f0 + 1);

      // reset mid-frame
      r0 = readies;
      start_enable();
      repeat (79) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("mid_rst_cs_n", int'(bus.adc_cs_n), 1);
      chk("mid_rst_sclk", int'(bus.adc_sclk), 1);
      chk("mid_rst_data", int'(bus.data_out), 0);
      chk("mid_rst_ready", int'(bus.data_ready), 0);
      bus.enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (300) @(posedge clk);
      chk("no_ready_after_reset", readies, r0);
      chk("data_after_reset", int'(bus.data_out), 0);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
